// File: rtl/pulse_stretcher_pkg.sv
// Shared types and width helpers for the pulse stretcher.
// Holds the FSM state encoding used by the top level.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Timer only has to hold values up to max(HIGH,LOW)-1; keep at least one bit.
    function automatic int timer_width(input int high_cycles, input int low_cycles);
        int m;
        m = (high_cycles > low_cycles) ? high_cycles : low_cycles;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

    function automatic int pend_width(input int pend_max);
        return (pend_max < 1) ? 1 : $clog2(pend_max + 1);
    endfunction

endpackage

// File: rtl/pulse_stretcher_sat_counter.sv
// Up/down counter saturating at MAX; flags an increment that could not be stored.
// The drop flag is registered and lasts exactly one cycle per lost event.
module pulse_stretcher_sat_counter #(
    parameter int MAX = 3,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_drop
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_count <= '0;
            o_drop  <= 1'b0;
        end else begin
            o_drop <= 1'b0;
            if (i_inc && !i_dec) begin
                if (o_count == MAX_V) begin
                    o_drop <= 1'b1;
                end else begin
                    o_count <= o_count + W'(1);
                end
            end else if (i_dec && !i_inc) begin
                o_count <= o_count - W'(1);
            end
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into HIGH windows of HIGH_CYCLES followed by a
// LOW gap of LOW_CYCLES; events arriving while busy are queued in a saturating counter.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 2,
    parameter int PEND_MAX    = 3,
    localparam int PW         = pend_width(PEND_MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pulse_in,
    output logic          level_out,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          overflow
);

    localparam int TW = timer_width(HIGH_CYCLES, LOW_CYCLES);
    localparam logic [TW-1:0] HI_LOAD = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0] LO_LOAD = TW'(LOW_CYCLES - 1);

    generate
        if (HIGH_CYCLES < 1 || LOW_CYCLES < 1 || PEND_MAX < 1) begin : g_bad_param
            $error("pulse_stretcher: HIGH_CYCLES, LOW_CYCLES and PEND_MAX must all be >= 1");
        end
    endgenerate

    state_t        r_state;
    logic [TW-1:0] r_timer;

    logic w_pend_nz;
    logic w_timer_done;
    logic w_inc;
    logic w_dec;

    assign w_pend_nz    = (pending != '0);
    assign w_timer_done = (r_timer == '0);

    // A queued event is taken at GAP exit, or in IDLE should one have arrived on
    // the very cycle the gap ended with an empty queue.
    assign w_dec = w_pend_nz && ((r_state == ST_IDLE) ||
                                 (r_state == ST_GAP && w_timer_done));
    assign w_inc = pulse_in && ((r_state == ST_HOLD) || (r_state == ST_GAP) ||
                                (r_state == ST_IDLE && w_pend_nz));

    pulse_stretcher_sat_counter #(
        .MAX (PEND_MAX),
        .W   (PW)
    ) u_pending (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .o_count (pending),
        .o_drop  (overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            level_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pulse_in || w_pend_nz) begin
                        r_state   <= ST_HOLD;
                        r_timer   <= HI_LOAD;
                        level_out <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_timer_done) begin
                        r_state   <= ST_GAP;
                        r_timer   <= LO_LOAD;
                        level_out <= 1'b0;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                ST_GAP: begin
                    if (!w_timer_done) begin
                        r_timer <= r_timer - TW'(1);
                    end else if (w_pend_nz) begin
                        r_state   <= ST_HOLD;
                        r_timer   <= HI_LOAD;
                        level_out <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_timer   <= '0;
                    level_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: an event-count model checked every cycle,
// plus hand-computed expectations at the key cycles of each scenario.
module tb_pulse_stretcher;

    localparam int H  = 4;
    localparam int L  = 2;
    localparam int PM = 3;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          pulse_in = 1'b0;
    logic          level_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    int windows = 0;
    bit chk_en = 1'b0;
    bit prev_lvl = 1'b0;

    // Model: remaining HIGH cycles, remaining LOW cycles, queued events.
    int m_hi = 0;
    int m_lo = 0;
    int m_pend = 0;
    bit m_ovf = 1'b0;

    pulse_stretcher #(
        .HIGH_CYCLES (H),
        .LOW_CYCLES  (L),
        .PEND_MAX    (PM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_in  (pulse_in),
        .level_out (level_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi   <= 0;
            m_lo   <= 0;
            m_pend <= 0;
            m_ovf  <= 1'b0;
        end else begin : model_step
            automatic int hi;
            automatic int lo;
            automatic int p;
            automatic bit inc;
            automatic bit dec;
            automatic bit ovf;
            hi = m_hi; lo = m_lo; p = m_pend;
            inc = 1'b0; dec = 1'b0; ovf = 1'b0;
            if (hi > 0) begin
                hi = hi - 1;
                if (hi == 0) lo = L;
                inc = pulse_in;
            end else if (lo > 0) begin
                lo = lo - 1;
                if (lo == 0 && p > 0) begin
                    dec = 1'b1;
                    hi = H;
                end
                inc = pulse_in;
            end else if (p > 0) begin
                dec = 1'b1;
                hi = H;
                inc = pulse_in;
            end else if (pulse_in) begin
                hi = H;
            end
            if (inc && !dec) begin
                if (p == PM) ovf = 1'b1;
                else p = p + 1;
            end else if (dec && !inc) begin
                p = p - 1;
            end
            m_hi   <= hi;
            m_lo   <= lo;
            m_pend <= p;
            m_ovf  <= ovf;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            checks = checks + 4;
            if (level_out !== (m_hi > 0)) begin
                errors = errors + 1;
                $display("FAIL model_level t=%0t: got %b expected %b", $time, level_out, (m_hi > 0));
            end
            if (busy !== (m_hi > 0 || m_lo > 0)) begin
                errors = errors + 1;
                $display("FAIL model_busy t=%0t: got %b expected %b", $time, busy, (m_hi > 0 || m_lo > 0));
            end
            if (pending !== PW'(m_pend)) begin
                errors = errors + 1;
                $display("FAIL model_pending t=%0t: got %0d expected %0d", $time, pending, m_pend);
            end
            if (overflow !== m_ovf) begin
                errors = errors + 1;
                $display("FAIL model_overflow t=%0t: got %b expected %b", $time, overflow, m_ovf);
            end
            if (level_out && !prev_lvl) windows = windows + 1;
            prev_lvl = level_out;
        end else begin
            prev_lvl = 1'b0;
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("check %s ok (%0d)", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200 && busy !== 1'b0; i++) tick();
        lit(name, int'(busy), 0);
        ticks(2);
    endtask

    initial begin
        // 1: asynchronous reset between edges
        #3 rst_n = 1'b0;
        #1;
        lit("rst_level", int'(level_out), 0);
        lit("rst_busy", int'(busy), 0);
        lit("rst_pending", int'(pending), 0);
        lit("rst_overflow", int'(overflow), 0);
        chk_en = 1'b1;
        #18 rst_n = 1'b1;
        ticks(3);
        lit("post_rst_level", int'(level_out), 0);
        lit("post_rst_busy", int'(busy), 0);

        // 2: single pulse at t
        pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        lit("t2_level_t1", int'(level_out), 1);
        lit("t2_busy_t1", int'(busy), 1);
        ticks(3);
        lit("t2_level_t4", int'(level_out), 1);
        tick();
        lit("t2_level_t5", int'(level_out), 0);
        lit("t2_busy_t5", int'(busy), 1);
        tick();
        lit("t2_busy_t6", int'(busy), 1);
        tick();
        lit("t2_busy_t7", int'(busy), 0);
        ticks(2);

        // 3: second pulse at t+2 while in HOLD
        pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        tick();
        pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        lit("t3_pending_t3", int'(pending), 1);
        ticks(3);
        lit("t3_level_t6", int'(level_out), 0);
        tick();
        lit("t3_level_t7", int'(level_out), 1);
        lit("t3_pending_t7", int'(pending), 0);
        ticks(3);
        lit("t3_level_t10", int'(level_out), 1);
        tick();
        lit("t3_level_t11", int'(level_out), 0);
        tick();
        lit("t3_busy_t12", int'(busy), 1);
        tick();
        lit("t3_busy_t13", int'(busy), 0);
        ticks(2);

        // 4: pulse at t then five more at t+1..t+5
        windows = 0;
        pulse_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 3) begin
                lit("t4_pending_t4", int'(pending), 3);
                lit("t4_overflow_t4", int'(overflow), 0);
            end
            if (i == 4) lit("t4_overflow_t5", int'(overflow), 1);
        end
        pulse_in = 1'b0;
        lit("t4_overflow_t6", int'(overflow), 1);
        tick();
        lit("t4_overflow_t7", int'(overflow), 0);
        wait_idle("t4_idle");
        lit("t4_windows", windows, 4);

        // 5: pending=1, extra pulse on the final GAP cycle
        pulse_in = 1'b1; ticks(2); pulse_in = 1'b0;
        ticks(4);
        lit("t5_level_t6", int'(level_out), 0);
        lit("t5_pending_t6", int'(pending), 1);
        pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        lit("t5_pending_t7", int'(pending), 1);
        lit("t5_overflow_t7", int'(overflow), 0);
        lit("t5_level_t7", int'(level_out), 1);
        wait_idle("t5_idle");

        // 6: asynchronous reset in HOLD with pending=2
        pulse_in = 1'b1; ticks(3); pulse_in = 1'b0;
        lit("t6_pending", int'(pending), 2);
        lit("t6_level_hold", int'(level_out), 1);
        #2 rst_n = 1'b0;
        #1;
        lit("t6_rst_level", int'(level_out), 0);
        lit("t6_rst_pending", int'(pending), 0);
        lit("t6_rst_busy", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        windows = 0;
        ticks(20);
        lit("t6_windows_after", windows, 0);
        lit("t6_busy_after", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
